// File: rtl/dual_port_ram_init_if.sv
// Two-port RAM request/response bundle: master drives requests, slave (the RAM) returns data and status.
interface dual_port_ram_init_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  cs_0;
  logic                  we_0;
  logic                  re_0;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic [DATA_WIDTH-1:0] rdata_0;
  logic                  rvalid_0;

  logic                  cs_1;
  logic                  we_1;
  logic                  re_1;
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [DATA_WIDTH-1:0] wdata_1;
  logic [DATA_WIDTH-1:0] rdata_1;
  logic                  rvalid_1;

  logic                  init_busy;
  logic                  coll;
  logic [1:0]            addr_err;
  logic [1:0]            par_err;

  modport master (
    output cs_0, we_0, re_0, addr_0, wdata_0,
    output cs_1, we_1, re_1, addr_1, wdata_1,
    input  rdata_0, rvalid_0, rdata_1, rvalid_1,
    input  init_busy, coll, addr_err, par_err
  );

  modport slave (
    input  cs_0, we_0, re_0, addr_0, wdata_0,
    input  cs_1, we_1, re_1, addr_1, wdata_1,
    output rdata_0, rvalid_0, rdata_1, rvalid_1,
    output init_busy, coll, addr_err, par_err
  );
endinterface

// File: rtl/dual_port_ram_init.sv
// True dual-port RAM, cleared after reset, fixed-winner write collisions; DPRAM_PARITY_EN adds per-word parity.
// Latency: 1-cycle registered reads; no backpressure, all requests are dropped while init_busy is high.
module dual_port_ram_init #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DEPTH      = 64,
  parameter int                    WIN_PORT   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_port_ram_init_if.slave  bus
);

`ifdef DPRAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int                    IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                    MW      = DATA_WIDTH + PW;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_busy_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic                  rvalid0_q, rvalid1_q;
  logic                  coll_q;
  logic [1:0]            addr_err_q;
  logic [1:0]            par_err_q;

  logic [MW-1:0] mem_q [0:(1<<IW)-1];

  function automatic logic [MW-1:0] mk_word(input logic [DATA_WIDTH-1:0] d);
`ifdef DPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic            run;
  logic            wr0, wr1, rd0, rd1;
  logic            inr0, inr1;
  logic            same;
  logic            we0_eff, we1_eff;
  logic [IW-1:0]   idx0, idx1;
  logic [MW-1:0]   rword0, rword1;
  logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
  logic [1:0]      par_bad_d;

  assign run  = (state_q == ST_RUN);
  assign wr0  = run & bus.cs_0 & bus.we_0;
  assign wr1  = run & bus.cs_1 & bus.we_1;
  assign rd0  = run & bus.cs_0 & ~bus.we_0 & bus.re_0;
  assign rd1  = run & bus.cs_1 & ~bus.we_1 & bus.re_1;
  assign inr0 = ({1'b0, bus.addr_0} < DEPTH_W);
  assign inr1 = ({1'b0, bus.addr_1} < DEPTH_W);
  assign idx0 = bus.addr_0[IW-1:0];
  assign idx1 = bus.addr_1[IW-1:0];

  // Only in-range writes can collide; the losing port's write is suppressed.
  assign same    = wr0 & wr1 & inr0 & inr1 & (bus.addr_0 == bus.addr_1);
  assign we0_eff = wr0 & inr0 & ~(same & (WIN_PORT != 0));
  assign we1_eff = wr1 & inr1 & ~(same & (WIN_PORT == 0));

  assign rword0   = mem_q[idx0];
  assign rword1   = mem_q[idx1];
  assign rdata0_d = inr0 ? rword0[DATA_WIDTH-1:0] : '0;
  assign rdata1_d = inr1 ? rword1[DATA_WIDTH-1:0] : '0;

`ifdef DPRAM_PARITY_EN
  assign par_bad_d = {^rword1, ^rword0};
`else
  assign par_bad_d = '0;
`endif

  // Storage carries no reset; the init sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q[IW-1:0]] <= mk_word(INIT_VALUE);
    end else begin
      if (we0_eff) mem_q[idx0] <= mk_word(bus.wdata_0);
      if (we1_eff) mem_q[idx1] <= mk_word(bus.wdata_1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      coll_q      <= 1'b0;
      addr_err_q  <= '0;
      par_err_q   <= '0;
    end else begin
      rvalid0_q  <= rd0;
      rvalid1_q  <= rd1;
      if (rd0) rdata0_q <= rdata0_d;
      if (rd1) rdata1_q <= rdata1_d;
      coll_q     <= same;
      addr_err_q <= {(wr1 | rd1) & ~inr1, (wr0 | rd0) & ~inr0};
      par_err_q  <= par_bad_d & {rd1 & inr1, rd0 & inr0};
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.init_busy = init_busy_q;
  assign bus.rdata_0   = rdata0_q;
  assign bus.rdata_1   = rdata1_q;
  assign bus.rvalid_0  = rvalid0_q;
  assign bus.rvalid_1  = rvalid1_q;
  assign bus.coll      = coll_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.par_err   = par_err_q;

endmodule
